// File: rtl/bitwise_sequencer_pkg.sv
// Shared ALU definitions: sequencer state encoding, bitwise op codes and sizing helpers.
package bitwise_sequencer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NOT  = 2'd3;

    // Byte index width; a single-byte build still needs a 1-bit index.
    function automatic int idx_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/bitwise_sequencer.sv
// Drives one 8-bit bitwise unit a byte per cycle, LSB first, chaining carry between bytes,
// and returns the assembled word plus the final carry.
module bitwise_sequencer
    import bitwise_sequencer_pkg::*;
#(
    parameter int BYTES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [8*BYTES-1:0] req_a,
    input  logic [8*BYTES-1:0] req_b,
    input  logic [1:0]         req_op,
    input  logic               req_cin,
    input  logic               req_invc,
    output logic [7:0]         bw_a,
    output logic [7:0]         bw_b,
    output logic [1:0]         bw_op,
    output logic               bw_cin,
    output logic               bw_invc,
    input  logic [7:0]         bw_q,
    input  logic               bw_cout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [8*BYTES-1:0] rsp_q,
    output logic               rsp_cout
);

    localparam int W  = 8 * BYTES;
    localparam int IW = idx_width(BYTES);
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]    op_q, op_d;
    logic          cin_q, cin_d, invc_q, invc_d;
    logic          carry_q, carry_d, cout_q, cout_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cin_d   = cin_q;
        invc_d  = invc_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    cin_d   = req_cin;
                    invc_d  = req_invc;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < BYTES; i++)
                    if (idx_q == IW'(i)) res_d[8*i +: 8] = bw_q;
                carry_d = bw_cout;
                if (idx_q == LAST) begin
                    cout_d  = bw_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            invc_q  <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            invc_q  <= invc_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            res_q   <= res_d;
        end
    end

    // Unit inputs come only from latched operands, so the unit stays quiet outside RUN.
    always_comb begin
        bw_a    = '0;
        bw_b    = '0;
        bw_op   = '0;
        bw_cin  = 1'b0;
        bw_invc = 1'b0;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < BYTES; i++) begin
                if (idx_q == IW'(i)) begin
                    bw_a = a_q[8*i +: 8];
                    bw_b = b_q[8*i +: 8];
                end
            end
            bw_op   = op_q;
            bw_cin  = (idx_q == '0) ? cin_q : carry_q;
            bw_invc = (idx_q == LAST) ? invc_q : 1'b0;
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_q     = res_q;
    assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_bitwise_sequencer.sv
// Scoreboard bench for bitwise_sequencer: a 2-byte and a 1-byte build, each driving an XOR/parity stub unit.
module tb_bitwise_sequencer;
    import bitwise_sequencer_pkg::*;

    typedef struct packed {
        logic [15:0] q;
        logic        cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int vecs = 0;
    int errs = 0;
    int acc_cyc = 0;
    exp_t sb2[$];
    exp_t sb1[$];

    logic        req_valid2, req_ready2, req_cin2, req_invc2;
    logic [15:0] req_a2, req_b2, rsp_q2;
    logic [1:0]  req_op2, bw_op2;
    logic [7:0]  bw_a2, bw_b2, bw_q2;
    logic        bw_cin2, bw_invc2, bw_cout2, rsp_valid2, rsp_ready2, rsp_cout2;

    logic        req_valid1, req_ready1, req_cin1, req_invc1;
    logic [7:0]  req_a1, req_b1, rsp_q1;
    logic [1:0]  req_op1, bw_op1;
    logic [7:0]  bw_a1, bw_b1, bw_q1;
    logic        bw_cin1, bw_invc1, bw_cout1, rsp_valid1, rsp_ready1, rsp_cout1;

    assign bw_q2    = bw_a2 ^ bw_b2;
    assign bw_cout2 = bw_cin2 ^ (^bw_a2) ^ bw_invc2;
    assign bw_q1    = bw_a1 ^ bw_b1;
    assign bw_cout1 = bw_cin1 ^ (^bw_a1) ^ bw_invc1;

    bitwise_sequencer #(.BYTES(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_a(req_a2), .req_b(req_b2), .req_op(req_op2), .req_cin(req_cin2), .req_invc(req_invc2),
        .bw_a(bw_a2), .bw_b(bw_b2), .bw_op(bw_op2), .bw_cin(bw_cin2), .bw_invc(bw_invc2),
        .bw_q(bw_q2), .bw_cout(bw_cout2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_q(rsp_q2), .rsp_cout(rsp_cout2)
    );

    bitwise_sequencer #(.BYTES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .req_op(req_op1), .req_cin(req_cin1), .req_invc(req_invc1),
        .bw_a(bw_a1), .bw_b(bw_b1), .bw_op(bw_op1), .bw_cin(bw_cin1), .bw_invc(bw_invc1),
        .bw_q(bw_q1), .bw_cout(bw_cout1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_q(rsp_q1), .rsp_cout(rsp_cout1)
    );

    // Reference: byte-wise XOR, carry = cin ^ parity of every A byte ^ invc.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic invc, input int nb);
        exp_t e;
        logic c;
        logic [7:0] ab;
        c   = cin;
        e.q = '0;
        for (int i = 0; i < nb; i++) begin
            ab = a[8*i +: 8];
            e.q[8*i +: 8] = ab ^ b[8*i +: 8];
            c = c ^ (^ab) ^ ((i == nb - 1) ? invc : 1'b0);
        end
        e.cout = c;
        return e;
    endfunction

    task automatic issue2(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                          input logic cin, input logic invc, output bit ok);
        req_a2 = a; req_b2 = b; req_op2 = op; req_cin2 = cin; req_invc2 = invc;
        req_valid2 = 1'b1;
        sb2.push_back(model(a, b, cin, invc, 2));
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready2) begin ok = 1; acc_cyc = cnt; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        req_valid2 = 1'b0;
    endtask

    task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic invc, output bit ok);
        req_a1 = a; req_b1 = b; req_op1 = OP_XOR; req_cin1 = cin; req_invc1 = invc;
        req_valid1 = 1'b1;
        sb1.push_back(model({8'h00, a}, {8'h00, b}, cin, invc, 1));
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready1) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        req_valid1 = 1'b0;
    endtask

    task automatic collect2(inout int cyc, output bit ok, output logic [15:0] q,
                            output logic c, output exp_t e);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid2) begin ok = 1; break; end
            @(negedge clk);
            cyc++;
        end
        q = rsp_q2;
        c = rsp_cout2;
        e = (sb2.size() > 0) ? sb2.pop_front() : '0;
        if (ok && rsp_ready2) @(negedge clk);
    endtask

    task automatic collect1(inout int cyc, output bit ok, output logic [15:0] q,
                            output logic c, output exp_t e);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid1) begin ok = 1; break; end
            @(negedge clk);
            cyc++;
        end
        q = {8'h00, rsp_q1};
        c = rsp_cout1;
        e = (sb1.size() > 0) ? sb1.pop_front() : '0;
        if (ok && rsp_ready1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if ({req_ready2, rsp_valid2, rsp_q2, rsp_cout2, bw_a2, bw_b2, bw_op2, bw_cin2, bw_invc2} !== '0) begin
            errs++;
            $display("FAIL reset_hold2: ready=%b valid=%b q=%h cout=%b bw_a=%h bw_b=%h, all required 0",
                     req_ready2, rsp_valid2, rsp_q2, rsp_cout2, bw_a2, bw_b2);
        end
        vecs++;
        if ({req_ready1, rsp_valid1, rsp_q1, rsp_cout1, bw_a1, bw_b1, bw_op1, bw_cin1, bw_invc1} !== '0) begin
            errs++;
            $display("FAIL reset_hold1: ready=%b valid=%b q=%h bw_a=%h, all required 0",
                     req_ready1, rsp_valid1, rsp_q1, bw_a1);
        end
        rst = 1'b0;
        #1;
        vecs++;
        if (req_ready2 !== 1'b1 || {rsp_valid2, rsp_q2, rsp_cout2, bw_a2, bw_b2, bw_op2, bw_cin2, bw_invc2} !== '0) begin
            errs++;
            $display("FAIL reset_release2: ready=%b valid=%b q=%h bw_a=%h, required ready=1 rest 0",
                     req_ready2, rsp_valid2, rsp_q2, bw_a2);
        end
        vecs++;
        if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin
            errs++;
            $display("FAIL reset_release1: ready=%b valid=%b, required 1/0", req_ready1, rsp_valid1);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok; int cyc; logic [15:0] q; logic c; exp_t e;
        issue2(16'h12F0, 16'h0FF0, OP_XOR, 1'b0, 1'b0, ok);
        vecs++;
        if (!ok || bw_a2 !== 8'hF0 || bw_b2 !== 8'hF0 || bw_op2 !== OP_XOR) begin
            errs++;
            $display("FAIL basic_byte0: ok=%0d bw_a=%h bw_b=%h op=%0d, required F0 F0 %0d", ok, bw_a2, bw_b2, bw_op2, OP_XOR);
        end
        @(negedge clk);
        vecs++;
        if (bw_a2 !== 8'h12 || bw_b2 !== 8'h0F) begin
            errs++;
            $display("FAIL basic_byte1: bw_a=%h bw_b=%h, required 12 0F", bw_a2, bw_b2);
        end
        cyc = 2;
        collect2(cyc, ok, q, c, e);
        vecs++;
        if (!ok || cyc != 3 || q !== e.q || q !== 16'h1D00 || c !== e.cout) begin
            errs++;
            $display("FAIL basic_rsp: ok=%0d lat=%0d q=%h cout=%b, required lat=3 q=%h cout=%b", ok, cyc, q, c, e.q, e.cout);
        end
    endtask

    task automatic test_carry();
        bit ok; int cyc; logic [15:0] q; logic c; exp_t e;
        issue2(16'h0100, 16'h0000, OP_AND, 1'b1, 1'b1, ok);
        vecs++;
        if (!ok || bw_cin2 !== 1'b1 || bw_invc2 !== 1'b0 || bw_cout2 !== 1'b1) begin
            errs++;
            $display("FAIL carry_byte0: cin=%b invc=%b cout=%b, required 1 0 1", bw_cin2, bw_invc2, bw_cout2);
        end
        @(negedge clk);
        vecs++;
        if (bw_cin2 !== 1'b1 || bw_invc2 !== 1'b1) begin
            errs++;
            $display("FAIL carry_byte1: cin=%b invc=%b, required 1 1", bw_cin2, bw_invc2);
        end
        cyc = 2;
        collect2(cyc, ok, q, c, e);
        vecs++;
        if (!ok || q !== e.q || c !== e.cout || c !== 1'b1) begin
            errs++;
            $display("FAIL carry_rsp: q=%h cout=%b, required q=%h cout=1", q, c, e.q);
        end
    endtask

    task automatic test_stall();
        bit ok; int cyc; logic [15:0] q, held; logic c; exp_t e;
        rsp_ready2 = 1'b0;
        issue2(16'hA55A, 16'h3C3C, OP_OR, 1'b0, 1'b1, ok);
        cyc = 1;
        collect2(cyc, ok, q, c, e);
        vecs++;
        if (!ok || q !== e.q || c !== e.cout) begin
            errs++;
            $display("FAIL stall_rsp1: q=%h cout=%b, required q=%h cout=%b", q, c, e.q, e.cout);
        end
        held = rsp_q2;
        req_a2 = 16'h7E81; req_b2 = 16'h0F0F; req_cin2 = 1'b1; req_invc2 = 1'b0; req_valid2 = 1'b1;
        sb2.push_back(model(16'h7E81, 16'h0F0F, 1'b1, 1'b0, 2));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vecs++;
            if (rsp_valid2 !== 1'b1 || rsp_q2 !== held || req_ready2 !== 1'b0) begin
                errs++;
                $display("FAIL stall_hold%0d: valid=%b q=%h ready=%b, required 1 %h 0", i, rsp_valid2, rsp_q2, req_ready2, held);
            end
        end
        rsp_ready2 = 1'b1;
        @(negedge clk);
        vecs++;
        if (rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1) begin
            errs++;
            $display("FAIL stall_release: valid=%b ready=%b, required 0 1", rsp_valid2, req_ready2);
        end
        @(negedge clk);
        req_valid2 = 1'b0;
        vecs++;
        if (req_ready2 !== 1'b0 || bw_a2 !== 8'h81) begin
            errs++;
            $display("FAIL stall_accept: ready=%b bw_a=%h, required 0 81", req_ready2, bw_a2);
        end
        cyc = 1;
        collect2(cyc, ok, q, c, e);
        vecs++;
        if (!ok || q !== e.q || c !== e.cout || sb2.size() != 0) begin
            errs++;
            $display("FAIL stall_rsp2: q=%h cout=%b left=%0d, required q=%h cout=%b left=0", q, c, sb2.size(), e.q, e.cout);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc; logic [15:0] q; logic c; exp_t e;
        issue2(16'hBEEF, 16'h1234, OP_XOR, 1'b1, 1'b0, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        void'(sb2.pop_back());
        vecs++;
        if ({bw_a2, bw_b2, bw_op2, bw_cin2, bw_invc2, rsp_valid2, req_ready2, rsp_q2, rsp_cout2} !== '0) begin
            errs++;
            $display("FAIL abort_outputs: bw_a=%h bw_b=%h valid=%b ready=%b q=%h, all required 0",
                     bw_a2, bw_b2, rsp_valid2, req_ready2, rsp_q2);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecs++;
            if (rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1 || bw_a2 !== 8'h00) begin
                errs++;
                $display("FAIL abort_idle%0d: valid=%b ready=%b bw_a=%h, required 0 1 00", i, rsp_valid2, req_ready2, bw_a2);
            end
        end
        issue2(16'h00FF, 16'hFF00, OP_XOR, 1'b0, 1'b0, ok);
        cyc = 1;
        collect2(cyc, ok, q, c, e);
        vecs++;
        if (!ok || cyc != 3 || q !== e.q || c !== e.cout) begin
            errs++;
            $display("FAIL abort_recover: lat=%0d q=%h cout=%b, required lat=3 q=%h cout=%b", cyc, q, c, e.q, e.cout);
        end
    endtask

    task automatic test_bytes1();
        bit ok; int cyc; logic [15:0] q; logic c; exp_t e;
        logic [7:0] av [3] = '{8'hA5, 8'h07, 8'hFF};
        logic [7:0] bv [3] = '{8'h3C, 8'h70, 8'h01};
        logic       cv [3] = '{1'b1, 1'b0, 1'b1};
        logic       iv [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            issue1(av[k], bv[k], cv[k], iv[k], ok);
            vecs++;
            if (!ok || bw_a1 !== av[k] || bw_cin1 !== cv[k] || bw_invc1 !== iv[k]) begin
                errs++;
                $display("FAIL b1_run%0d: bw_a=%h cin=%b invc=%b, required %h %b %b", k, bw_a1, bw_cin1, bw_invc1, av[k], cv[k], iv[k]);
            end
            cyc = 1;
            collect1(cyc, ok, q, c, e);
            vecs++;
            if (!ok || cyc != 2 || q !== e.q || c !== e.cout) begin
                errs++;
                $display("FAIL b1_rsp%0d: lat=%0d q=%h cout=%b, required lat=2 q=%h cout=%b", k, cyc, q, c, e.q, e.cout);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc, prev; logic [15:0] q; logic c; exp_t e;
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            issue2(16'($urandom), 16'($urandom), 2'($urandom_range(3)), 1'($urandom), 1'($urandom), ok);
            if (prev >= 0) begin
                vecs++;
                if (acc_cyc - prev != 4) begin
                    errs++;
                    $display("FAIL b2b_spacing%0d: %0d cycles, required 4", k, acc_cyc - prev);
                end
            end
            prev = acc_cyc;
            cyc = 1;
            collect2(cyc, ok, q, c, e);
            vecs++;
            if (!ok || cyc != 3 || q !== e.q || c !== e.cout) begin
                errs++;
                $display("FAIL b2b_rsp%0d: lat=%0d q=%h cout=%b, required lat=3 q=%h cout=%b", k, cyc, q, c, e.q, e.cout);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid2 = 1'b0; req_a2 = '0; req_b2 = '0; req_op2 = '0; req_cin2 = 1'b0; req_invc2 = 1'b0;
        req_valid1 = 1'b0; req_a1 = '0; req_b1 = '0; req_op1 = '0; req_cin1 = 1'b0; req_invc1 = 1'b0;
        rsp_ready2 = 1'b1;
        rsp_ready1 = 1'b1;
        test_reset();
        test_basic();
        test_carry();
        test_stall();
        test_reset_mid();
        test_bytes1();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
